adxl345_axis_sample_assembler: RTL and testbench
================================================

Name: adxl345_axis_sample_assembler

Overview:
- Downstream consumer of the ADXL345 SPI master's MISO byte stream during an axis-data burst read (command 0xF2: multi-byte read from DATAX0).
- Collects the six data bytes DATAX0..DATAZ1 in one chip-select frame and rebuilds signed X/Y/Z samples.
- Presents each sample through a single-entry valid/ready output register, and counts malformed frames and dropped samples.

Parameters:
LEFT_JUSTIFIED, 1, 1 = device runs with DATA_FORMAT justify bit set (format write 0x04), so data is MSB-aligned; 0 = right-justified.
DATA_BITS, 10, significant sample bits (10 for fixed ±2g resolution).
FRAME_BYTES, 6, data bytes per frame after the command byte.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse when CS falls (start of SPI transaction)
frame_end  in  1  one-cycle pulse when CS rises (end of transaction)
byte_valid  in  1  one-cycle strobe; byte_data holds one complete received MISO byte
byte_data  in  8  received byte, first byte = DATAX0
sample_x  out  16  signed X sample, sign-extended
sample_y  out  16  signed Y sample
sample_z  out  16  signed Z sample
sample_valid  out  1  output register holds an unconsumed sample
sample_ready  in  1  consumer accepts sample when valid&&ready on a clk edge
short_frames  out  8  saturating count of frames ending with <FRAME_BYTES bytes
long_frames  out  8  saturating count of frames with >FRAME_BYTES bytes
overruns  out  8  saturating count of completed samples dropped because output was full
busy  out  1  high while in COLLECT

Behaviour:
- Reset (rst high at clk edge): state=IDLE, byte counter=0, staging bytes=0, sample_x/y/z=0, sample_valid=0, all counters=0, busy=0. Reset mid-frame discards partial data. The remainder of that frame is ignored until the next frame_start.
- FSM states: IDLE, COLLECT, COMMIT.
- IDLE: byte_valid ignored. frame_start -> COLLECT, counter=0.
- COLLECT: busy=1.
  - byte_valid with counter<FRAME_BYTES: store the byte in staging[counter], counter+1.
  - byte_valid with counter>=FRAME_BYTES: byte discarded, extra flag set.
  - frame_start in COLLECT restarts the frame: counter=0, extra flag cleared, no counter increments.
  - frame_end with counter==FRAME_BYTES and extra flag clear -> COMMIT.
  - frame_end with counter==FRAME_BYTES and extra flag set -> long_frames+1, IDLE.
  - frame_end with counter<FRAME_BYTES -> short_frames+1, IDLE.
  - byte_valid and frame_end in the same cycle: the byte is counted first, then the frame_end check is made.
- COMMIT (one cycle), always -> IDLE:
  - Raw word per axis is {hi,lo} (X = {staging[1],staging[0]}, etc.).
  - LEFT_JUSTIFIED=1: sample = raw >>> (16-DATA_BITS), arithmetic shift.
  - LEFT_JUSTIFIED=0: sample = sign-extend raw[DATA_BITS-1:0] to 16 bits.
- Output register load rule, evaluated in COMMIT:
  - Load if sample_valid==0, or if sample_valid&&sample_ready in this cycle (simultaneous consume and load). sample_valid stays/becomes 1.
  - Otherwise the new sample is dropped, overruns+1, and the held sample is unchanged.
- Consume: valid&&ready with no load in the same cycle -> sample_valid=0 next cycle. sample_x/y/z hold their last value.
- Latency: frame_end edge -> COMMIT next cycle -> sample_valid high the cycle after COMMIT (2 clk after frame_end).
- All counters saturate at 255 and never wrap.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Normal frame, LEFT_JUSTIFIED=1: bytes 0x40,0x00,0xC0,0xFF,0x00,0x80, then frame_end -> sample_x=0x0001, sample_y=0xFFFF, sample_z=0xFE00 (-512). sample_valid rises 2 clk after frame_end.
- Short frame: 4 bytes then frame_end -> short_frames=1, sample_valid stays 0. Next good frame is assembled correctly.
- Long frame: 7 bytes then frame_end -> long_frames=1, no sample. Overrun: hold sample_ready=0 across two good frames -> first sample retained, overruns=1. Counter saturation: 300 short frames -> short_frames=255.
- Simultaneous consume and load: sample_ready=1 exactly in the COMMIT cycle of the second frame -> sample_valid stays 1, outputs update to the second frame, overruns=0.
- Reset mid-frame: rst after 3 bytes -> all outputs 0. Remaining bytes and frame_end are ignored and no counter changes. Next frame_start+6 bytes yields a correct sample.
- Right-justified, LEFT_JUSTIFIED=0: X bytes 0xFF,0x03 -> sample_x=0xFFFF. X bytes 0xFF,0x01 -> sample_x=0x01FF (511).

Source files
------------

// File: rtl/adxl345_axis_sample_assembler_if.sv
// rtl/adxl345_axis_sample_assembler_if.sv - byte-stream in / sample-out bundle for the ADXL345 sample assembler
//
// Purpose: groups the SPI-byte input stream, the X/Y/Z sample output register
// handshake and the status counters into one bundle.
// master: the side that feeds bytes and consumes samples.
// slave : the assembler itself.
//   frame_start/frame_end : CS fall / CS rise one-cycle pulses
//   byte_valid/byte_data  : one received MISO byte per strobe
//   sample_x/y/z          : signed 16-bit samples
//   sample_valid/ready    : output register handshake
//   short/long_frames, overruns : saturating 8-bit error counters
//   busy                  : assembler is collecting a frame
interface adxl345_axis_sample_assembler_if;
   logic        frame_start;
   logic        frame_end;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic [15:0] sample_x;
   logic [15:0] sample_y;
   logic [15:0] sample_z;
   logic        sample_valid;
   logic        sample_ready;
   logic [7:0]  short_frames;
   logic [7:0]  long_frames;
   logic [7:0]  overruns;
   logic        busy;

   modport master (
      output frame_start, frame_end, byte_valid, byte_data, sample_ready,
      input  sample_x, sample_y, sample_z, sample_valid,
             short_frames, long_frames, overruns, busy
   );

   modport slave (
      input  frame_start, frame_end, byte_valid, byte_data, sample_ready,
      output sample_x, sample_y, sample_z, sample_valid,
             short_frames, long_frames, overruns, busy
   );
endinterface

// File: rtl/adxl345_axis_sample_assembler.sv
// rtl/adxl345_axis_sample_assembler.sv - rebuilds X/Y/Z samples from an ADXL345 DATAX0..DATAZ1 burst read
//
// Purpose: collects FRAME_BYTES data bytes within one chip-select frame,
// converts them to sign-extended 16-bit samples and holds the result in a
// single-entry valid/ready output register. Malformed frames and samples lost
// to a full output register are counted (saturating at 255).
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   sa  : slave side of adxl345_axis_sample_assembler_if (byte stream in,
//         samples, handshake, counters and busy out; all outputs registered)
module adxl345_axis_sample_assembler #(
   parameter int LEFT_JUSTIFIED = 1,
   parameter int DATA_BITS      = 10,
   parameter int FRAME_BYTES    = 6
) (
   input  logic                              clk,
   input  logic                              rst,
   adxl345_axis_sample_assembler_if.slave    sa
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_COMMIT  = 2'd2;

   localparam int               CNT_W = $clog2(FRAME_BYTES + 1);
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(FRAME_BYTES);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             extra_q, extra_d;
   logic [7:0]       stage_q [FRAME_BYTES];
   logic [7:0]       stage_d [FRAME_BYTES];
   logic [15:0]      sx_q, sx_d;
   logic [15:0]      sy_q, sy_d;
   logic [15:0]      sz_q, sz_d;
   logic             valid_q, valid_d;
   logic [7:0]       short_q, short_d;
   logic [7:0]       long_q, long_d;
   logic [7:0]       ovr_q, ovr_d;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Left-justified data carries the sign in bit 15, so an arithmetic shift
   // both aligns and sign-extends; right-justified data is sign-extended
   // from bit DATA_BITS-1.
   function automatic logic [15:0] conv(input logic [15:0] raw);
      if (LEFT_JUSTIFIED != 0)
         return $signed(raw) >>> (16 - DATA_BITS);
      else
         return {{(16 - DATA_BITS){raw[DATA_BITS-1]}}, raw[DATA_BITS-1:0]};
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      extra_d = extra_q;
      stage_d = stage_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      sz_d    = sz_q;
      valid_d = valid_q;
      short_d = short_q;
      long_d  = long_q;
      ovr_d   = ovr_q;

      // Consume; a load in COMMIT below overrides this.
      if (valid_q && sa.sample_ready)
         valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sa.frame_start) begin
               state_d = ST_COLLECT;
               cnt_d   = '0;
               extra_d = 1'b0;
            end
         end

         ST_COLLECT: begin
            if (sa.frame_start) begin
               cnt_d   = '0;
               extra_d = 1'b0;
            end else begin
               if (sa.byte_valid) begin
                  if (cnt_q < FULL) begin
                     stage_d[cnt_q] = sa.byte_data;
                     cnt_d          = cnt_q + 1'b1;
                  end else begin
                     extra_d = 1'b1;
                  end
               end
               // Uses the post-byte count so a byte coinciding with
               // frame_end is included in the length check.
               if (sa.frame_end) begin
                  state_d = ST_IDLE;
                  if (cnt_d == FULL) begin
                     if (extra_d)
                        long_d = sat_inc(long_q);
                     else
                        state_d = ST_COMMIT;
                  end else begin
                     short_d = sat_inc(short_q);
                  end
               end
            end
         end

         ST_COMMIT: begin
            state_d = ST_IDLE;
            if (!valid_q || sa.sample_ready) begin
               sx_d    = conv({stage_q[1], stage_q[0]});
               sy_d    = conv({stage_q[3], stage_q[2]});
               sz_d    = conv({stage_q[5], stage_q[4]});
               valid_d = 1'b1;
            end else begin
               ovr_d = sat_inc(ovr_q);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         extra_q <= 1'b0;
         for (int i = 0; i < FRAME_BYTES; i++)
            stage_q[i] <= 8'h00;
         sx_q    <= 16'h0000;
         sy_q    <= 16'h0000;
         sz_q    <= 16'h0000;
         valid_q <= 1'b0;
         short_q <= 8'h00;
         long_q  <= 8'h00;
         ovr_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         extra_q <= extra_d;
         stage_q <= stage_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         sz_q    <= sz_d;
         valid_q <= valid_d;
         short_q <= short_d;
         long_q  <= long_d;
         ovr_q   <= ovr_d;
      end
   end

   assign sa.sample_x     = sx_q;
   assign sa.sample_y     = sy_q;
   assign sa.sample_z     = sz_q;
   assign sa.sample_valid = valid_q;
   assign sa.short_frames = short_q;
   assign sa.long_frames  = long_q;
   assign sa.overruns     = ovr_q;
   assign sa.busy         = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_adxl345_axis_sample_assembler.sv
// tb/tb_adxl345_axis_sample_assembler.sv - self-checking bench for adxl345_axis_sample_assembler
module tb_adxl345_axis_sample_assembler;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   adxl345_axis_sample_assembler_if lj ();
   adxl345_axis_sample_assembler_if rj ();

   // Both instances see identical stimulus; they differ only in justification.
   assign rj.frame_start  = lj.frame_start;
   assign rj.frame_end    = lj.frame_end;
   assign rj.byte_valid   = lj.byte_valid;
   assign rj.byte_data    = lj.byte_data;
   assign rj.sample_ready = lj.sample_ready;

   adxl345_axis_sample_assembler #(.LEFT_JUSTIFIED(1), .DATA_BITS(10), .FRAME_BYTES(6))
      dut_lj (.clk(clk), .rst(rst), .sa(lj.slave));
   adxl345_axis_sample_assembler #(.LEFT_JUSTIFIED(0), .DATA_BITS(10), .FRAME_BYTES(6))
      dut_rj (.clk(clk), .rst(rst), .sa(rj.slave));

   typedef struct {
      logic [5:0][7:0] b;
      logic [15:0]     ex, ey, ez;
      logic [15:0]     rx, ry, rz;
   } vec_t;

   vec_t vt [4];
   int total = 0;
   int bad   = 0;

   // reference model state
   int m_valid, m_short, m_long, m_ovr;
   logic [15:0] m_x, m_y, m_z, m_rx, m_ry, m_rz;

   function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, b5,
                               input logic [15:0] ex, ey, ez, rx, ry, rz);
      vec_t v;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
      v.ex = ex; v.ey = ey; v.ez = ez; v.rx = rx; v.ry = ry; v.rz = rz;
      return v;
   endfunction

   // left-justified 10-bit: signed 16-bit value divided by 64, rounded toward -inf
   function automatic logic [15:0] ref_lj(input int raw);
      int v, q;
      v = (raw >= 32768) ? raw - 65536 : raw;
      if (v >= 0) q = v / 64;
      else        q = -((-v + 63) / 64);
      return 16'(q);
   endfunction

   // right-justified 10-bit: low ten bits as two's complement
   function automatic logic [15:0] ref_rj(input int raw);
      int v;
      v = raw % 1024;
      if (v >= 512) v = v - 1024;
      return 16'(v);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic pstart();
      lj.frame_start = 1'b1;
      tick();
      lj.frame_start = 1'b0;
   endtask

   task automatic pbyte(input logic [7:0] d);
      lj.byte_valid = 1'b1;
      lj.byte_data  = d;
      tick();
      lj.byte_valid = 1'b0;
   endtask

   task automatic pend();
      lj.frame_end = 1'b1;
      tick();
      lj.frame_end = 1'b0;
   endtask

   task automatic send_bytes(input logic [5:0][7:0] b, input int n);
      for (int i = 0; i < n; i++) pbyte(b[i]);
   endtask

   task automatic chk_sample(input string name, input vec_t v);
      chk({name, "_x"},  lj.sample_x, v.ex);
      chk({name, "_y"},  lj.sample_y, v.ey);
      chk({name, "_z"},  lj.sample_z, v.ez);
      chk({name, "_rx"}, rj.sample_x, v.rx);
      chk({name, "_ry"}, rj.sample_y, v.ry);
      chk({name, "_rz"}, rj.sample_z, v.rz);
   endtask

   task automatic good_frame(input vec_t v);
      pstart();
      send_bytes(v.b, 6);
      pend();
      tick();
   endtask

   task automatic consume();
      lj.sample_ready = 1'b1;
      tick();
      lj.sample_ready = 1'b0;
   endtask

   task automatic chk_model(input string name);
      chk({name, "_valid"}, {15'd0, lj.sample_valid}, 16'(m_valid));
      chk({name, "_short"}, {8'd0, lj.short_frames}, 16'(m_short));
      chk({name, "_long"},  {8'd0, lj.long_frames},  16'(m_long));
      chk({name, "_ovr"},   {8'd0, lj.overruns},     16'(m_ovr));
      if (m_valid != 0) begin
         chk({name, "_x"},  lj.sample_x, m_x);
         chk({name, "_y"},  lj.sample_y, m_y);
         chk({name, "_z"},  lj.sample_z, m_z);
         chk({name, "_rx"}, rj.sample_x, m_rx);
         chk({name, "_ry"}, rj.sample_y, m_ry);
         chk({name, "_rz"}, rj.sample_z, m_rz);
      end
   endtask

   initial begin
      lj.frame_start  = 1'b0;
      lj.frame_end    = 1'b0;
      lj.byte_valid   = 1'b0;
      lj.byte_data    = 8'h00;
      lj.sample_ready = 1'b0;

      vt[0] = mk(8'h40, 8'h00, 8'hC0, 8'hFF, 8'h00, 8'h80,
                 16'h0001, 16'hFFFF, 16'hFE00, 16'h0040, 16'hFFC0, 16'h0000);
      vt[1] = mk(8'hC0, 8'h7F, 8'h00, 8'h00, 8'h40, 8'hFF,
                 16'h01FF, 16'h0000, 16'hFFFD, 16'hFFC0, 16'h0000, 16'hFF40);
      vt[2] = mk(8'hFF, 8'hFF, 8'h3F, 8'h00, 8'h80, 8'h01,
                 16'hFFFF, 16'h0000, 16'h0006, 16'hFFFF, 16'h003F, 16'h0180);
      vt[3] = mk(8'hFF, 8'h03, 8'hFF, 8'h01, 8'h00, 8'h02,
                 16'h000F, 16'h0007, 16'h0008, 16'hFFFF, 16'h01FF, 16'hFE00);

      // reset state
      do_reset();
      chk("rst_x", lj.sample_x, 16'h0000);
      chk("rst_valid", {15'd0, lj.sample_valid}, 16'h0000);
      chk("rst_busy", {15'd0, lj.busy}, 16'h0000);
      chk("rst_cnt", {lj.short_frames, lj.long_frames}, 16'h0000);

      // table: normal frames with latency check and consume
      foreach (vt[i]) begin
         pstart();
         chk("busy", {15'd0, lj.busy}, 16'h0001);
         send_bytes(vt[i].b, 6);
         lj.frame_end = 1'b1;
         tick();
         lj.frame_end = 1'b0;
         chk("lat1_valid", {15'd0, lj.sample_valid}, 16'h0000);
         tick();
         chk("lat2_valid", {15'd0, lj.sample_valid}, 16'h0001);
         chk_sample($sformatf("vec%0d", i), vt[i]);
         consume();
         chk("consumed", {15'd0, lj.sample_valid}, 16'h0000);
         chk("hold_x", lj.sample_x, vt[i].ex);
      end

      // short frame, then good frame
      pstart();
      send_bytes(vt[0].b, 4);
      pend();
      tick();
      chk("short_cnt", {8'd0, lj.short_frames}, 16'd1);
      chk("short_valid", {15'd0, lj.sample_valid}, 16'h0000);
      good_frame(vt[1]);
      chk_sample("after_short", vt[1]);
      consume();

      // long frame: 7 bytes, last one coincides with frame_end
      pstart();
      send_bytes(vt[2].b, 6);
      lj.byte_valid = 1'b1;
      lj.byte_data  = 8'h55;
      lj.frame_end  = 1'b1;
      tick();
      lj.byte_valid = 1'b0;
      lj.frame_end  = 1'b0;
      tick();
      chk("long_cnt", {8'd0, lj.long_frames}, 16'd1);
      chk("long_valid", {15'd0, lj.sample_valid}, 16'h0000);

      // sixth byte coinciding with frame_end completes a good frame
      pstart();
      send_bytes(vt[2].b, 5);
      lj.byte_valid = 1'b1;
      lj.byte_data  = vt[2].b[5];
      lj.frame_end  = 1'b1;
      tick();
      lj.byte_valid = 1'b0;
      lj.frame_end  = 1'b0;
      tick();
      chk("merged_valid", {15'd0, lj.sample_valid}, 16'h0001);
      chk_sample("merged", vt[2]);
      consume();

      // overrun: two good frames with ready low
      good_frame(vt[0]);
      good_frame(vt[3]);
      chk("ovr_cnt", {8'd0, lj.overruns}, 16'd1);
      chk("ovr_valid", {15'd0, lj.sample_valid}, 16'h0001);
      chk_sample("ovr_kept", vt[0]);

      // simultaneous consume and load
      do_reset();
      good_frame(vt[0]);
      pstart();
      send_bytes(vt[1].b, 6);
      lj.frame_end = 1'b1;
      tick();
      lj.frame_end    = 1'b0;
      lj.sample_ready = 1'b1;
      tick();
      lj.sample_ready = 1'b0;
      chk("sim_valid", {15'd0, lj.sample_valid}, 16'h0001);
      chk("sim_ovr", {8'd0, lj.overruns}, 16'd0);
      chk_sample("sim", vt[1]);
      tick();
      chk("sim_hold", {15'd0, lj.sample_valid}, 16'h0001);

      // reset mid-frame
      consume();
      good_frame(vt[2]);
      pstart();
      send_bytes(vt[3].b, 3);
      do_reset();
      chk("mid_x", lj.sample_x, 16'h0000);
      chk("mid_valid", {15'd0, lj.sample_valid}, 16'h0000);
      chk("mid_busy", {15'd0, lj.busy}, 16'h0000);
      pbyte(8'h11);
      pbyte(8'h22);
      pbyte(8'h33);
      pend();
      tick();
      chk("mid_after_valid", {15'd0, lj.sample_valid}, 16'h0000);
      chk("mid_after_cnt", {lj.short_frames, lj.long_frames}, 16'h0000);
      chk("mid_after_ovr", {8'd0, lj.overruns}, 16'h0000);
      good_frame(vt[3]);
      chk_sample("mid_next", vt[3]);

      // randomized frames against the reference model
      do_reset();
      m_valid = 0; m_short = 0; m_long = 0; m_ovr = 0;
      m_x = 0; m_y = 0; m_z = 0; m_rx = 0; m_ry = 0; m_rz = 0;
      for (int f = 0; f < 60; f++) begin
         int len;
         int merge;
         logic [7:0] rb [8];
         len   = $urandom_range(0, 8);
         merge = (len > 0) ? $urandom_range(0, 1) : 0;
         for (int k = 0; k < 8; k++) rb[k] = 8'($urandom);
         pstart();
         for (int k = 0; k < len; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            lj.byte_valid = 1'b1;
            lj.byte_data  = rb[k];
            if (merge != 0 && k == len - 1) lj.frame_end = 1'b1;
            tick();
            lj.byte_valid = 1'b0;
            lj.frame_end  = 1'b0;
         end
         if (merge == 0) pend();
         tick();
         tick();
         if (len == 6) begin
            if (m_valid == 0) begin
               m_valid = 1;
               m_x  = ref_lj(int'({rb[1], rb[0]}));
               m_y  = ref_lj(int'({rb[3], rb[2]}));
               m_z  = ref_lj(int'({rb[5], rb[4]}));
               m_rx = ref_rj(int'({rb[1], rb[0]}));
               m_ry = ref_rj(int'({rb[3], rb[2]}));
               m_rz = ref_rj(int'({rb[5], rb[4]}));
            end else if (m_ovr < 255) begin
               m_ovr++;
            end
         end else if (len > 6) begin
            if (m_long < 255) m_long++;
         end else begin
            if (m_short < 255) m_short++;
         end
         chk_model($sformatf("rnd%0d", f));
         if ($urandom_range(0, 1) == 1) begin
            consume();
            m_valid = 0;
         end
      end

      // saturation of short_frames
      do_reset();
      for (int f = 0; f < 300; f++) begin
         pstart();
         pbyte(8'(f));
         pend();
      end
      tick();
      chk("sat_short", {8'd0, lj.short_frames}, 16'd255);
      chk("sat_long", {8'd0, lj.long_frames}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
